// File: rtl/race_scheduler.sv
// race_scheduler: shares one timed track between N_RACERS racers.
// Requests are arbitrated round-robin, one racer at a time receives a
// one-hot start, and each run is timed from start to done. A one-cycle
// result record is produced when a run ends.
//
// Optional feature: define RACE_TIMEOUT_EN to abort runs that reach
// TIMEOUT cycles without done. Without it a run waits indefinitely and
// result_timeout is constant 0.
//
// Handshake: a racer holds ready[i] to request the track. The scheduler
// raises start[i] (at most one bit) to grant it. The racer raises done[i]
// to end its run. After that it must lower both done[i] and ready[i]
// before the track is offered again.
module race_scheduler #(
    parameter int N_RACERS = 4,
    parameter int TIME_W   = 16,
    parameter int TIMEOUT  = 1000,
    localparam int ID_W    = (N_RACERS > 1) ? $clog2(N_RACERS) : 1
) (
    input  logic                clk,
    input  logic                rst_l,
    input  logic [N_RACERS-1:0] ready,
    input  logic [N_RACERS-1:0] done,
    output logic [N_RACERS-1:0] start,
    output logic                busy,
    output logic [ID_W-1:0]     grant_id,
    output logic                result_valid,
    output logic [ID_W-1:0]     result_id,
    output logic [TIME_W-1:0]   result_time,
    output logic                result_timeout,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_COOL = 2'd2
    } state_t;

    state_t                state_q;
    logic [N_RACERS-1:0]   start_q;
    logic                  busy_q;
    logic [ID_W-1:0]       grant_id_q;
    logic [ID_W-1:0]       rr_ptr_q;
    logic [TIME_W-1:0]     timer_q;
    logic                  result_valid_q;
    logic [ID_W-1:0]       result_id_q;
    logic [TIME_W-1:0]     result_time_q;
    logic                  result_timeout_q;

    logic                  sel_found;
    logic [ID_W-1:0]       sel_id;
    logic [ID_W-1:0]       cand;
    logic [N_RACERS-1:0]   sel_onehot;
    logic [ID_W-1:0]       rr_next;
    logic                  done_cur;
    logic                  ready_cur;

`ifdef RACE_TIMEOUT_EN
    localparam logic [TIME_W-1:0] TIMEOUT_LAST = TIME_W'(TIMEOUT - 1);
    localparam logic [TIME_W-1:0] TIMEOUT_VAL  = TIME_W'(TIMEOUT);
`else
    // TIMEOUT has no effect when the abort logic is not built.
    logic [31:0] timeout_unused;
    assign timeout_unused = 32'(TIMEOUT);
`endif

    // Only the granted racer's handshake bits matter while it owns the track.
    assign done_cur  = done[grant_id_q];
    assign ready_cur = ready[grant_id_q];

    // Pointer moves past the racer that just finished so it has lowest priority.
    assign rr_next = (grant_id_q == ID_W'(N_RACERS - 1)) ? '0 : grant_id_q + 1'b1;

    // Round-robin pick: first ready bit scanning upward from rr_ptr, wrapping.
    always_comb begin
        sel_found  = 1'b0;
        sel_id     = '0;
        cand       = '0;
        for (int i = 0; i < N_RACERS; i++) begin
            cand = ID_W'((int'(rr_ptr_q) + i) % N_RACERS);
            if (!sel_found && ready[cand]) begin
                sel_found = 1'b1;
                sel_id    = cand;
            end
        end
        sel_onehot = {{(N_RACERS-1){1'b0}}, 1'b1} << sel_id;
    end

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q          <= S_IDLE;
            start_q          <= '0;
            busy_q           <= 1'b0;
            grant_id_q       <= '0;
            rr_ptr_q         <= '0;
            timer_q          <= '0;
            result_valid_q   <= 1'b0;
            result_id_q      <= '0;
            result_time_q    <= '0;
            result_timeout_q <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (sel_found) begin
                        state_q    <= S_RUN;
                        start_q    <= sel_onehot;
                        grant_id_q <= sel_id;
                        timer_q    <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (done_cur) begin
                        // done wins over a same-edge timeout
                        state_q          <= S_COOL;
                        start_q          <= '0;
                        result_valid_q   <= 1'b1;
                        result_id_q      <= grant_id_q;
                        result_time_q    <= timer_q;
                        result_timeout_q <= 1'b0;
                        rr_ptr_q         <= rr_next;
                    end
`ifdef RACE_TIMEOUT_EN
                    else if (timer_q == TIMEOUT_LAST) begin
                        state_q          <= S_COOL;
                        start_q          <= '0;
                        result_valid_q   <= 1'b1;
                        result_id_q      <= grant_id_q;
                        result_time_q    <= TIMEOUT_VAL;
                        result_timeout_q <= 1'b1;
                        rr_ptr_q         <= rr_next;
                    end
`endif
                    else if (timer_q != '1) begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_COOL: begin
                    // Wait for the finished racer to release both handshake bits.
                    if (!done_cur && !ready_cur) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    start_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign start          = start_q;
    assign busy           = busy_q;
    assign grant_id       = grant_id_q;
    assign result_valid   = result_valid_q;
    assign result_id      = result_id_q;
    assign result_time    = result_time_q;
    assign result_timeout = result_timeout_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_race_scheduler.sv
// Bench for race_scheduler: a directed vector table applied cycle by cycle,
// then hand-written sequences for reset mid-run, round-robin rotation and
// the long-run / timeout behaviour.
module tb_race_scheduler;

    localparam int N  = 4;
    localparam int TW = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_l;
    logic [N-1:0]  ready;
    logic [N-1:0]  done;
    logic [N-1:0]  start;
    logic          busy;
    logic [1:0]    grant_id;
    logic          result_valid;
    logic [1:0]    result_id;
    logic [TW-1:0] result_time;
    logic          result_timeout;
    logic [1:0]    state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    int onehot_viol = 0;

    logic [1:0] exp_q[$];

    typedef struct packed {
        logic [3:0]  ready;
        logic [3:0]  done;
        logic [3:0]  start;
        logic        busy;
        logic [1:0]  grant;
        logic        rv;
        logic [1:0]  rid;
        logic [15:0] rtime;
        logic        rto;
    } vec_t;

    vec_t vecs[$];

    race_scheduler #(
        .N_RACERS(N),
        .TIME_W  (TW),
        .TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst_l         (rst_l),
        .ready         (ready),
        .done          (done),
        .start         (start),
        .busy          (busy),
        .grant_id      (grant_id),
        .result_valid  (result_valid),
        .result_id     (result_id),
        .result_time   (result_time),
        .result_timeout(result_timeout),
        .state_dbg     (state_dbg)
    );

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // At most one start bit may be high at any time.
    always @(negedge clk) begin
        if ($countones(start) > 1) onehot_viol++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic [3:0] r, input logic [3:0] d, input logic [3:0] s,
                           input logic b, input logic [1:0] g, input logic v,
                           input logic [1:0] id, input logic [15:0] t, input logic to);
        vec_t x;
        x.ready = r; x.done = d; x.start = s; x.busy = b; x.grant = g;
        x.rv = v; x.rid = id; x.rtime = t; x.rto = to;
        vecs.push_back(x);
    endtask

    function automatic logic [1:0] onehot_to_id(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
        return r;
    endfunction

    initial begin
        logic [1:0] eid;
        int         waited;
        int         cnt;

        // ready, done -> start, busy, grant, rv, rid, rtime, rto (after the edge)
        // single racer 1, done raised 5 cycles after start rises
        add_vec(4'b0010, 4'b0000, 4'b0010, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            add_vec(4'b0010, 4'b0000, 4'b0010, 1, 1, 0, 0, 0, 0);
        add_vec(4'b0010, 4'b0010, 4'b0000, 1, 1, 1, 1, 5, 0);
        add_vec(4'b0010, 4'b0010, 4'b0000, 1, 1, 0, 1, 5, 0);
        add_vec(4'b0010, 4'b0000, 4'b0000, 1, 1, 0, 1, 5, 0);
        add_vec(4'b0000, 4'b0010, 4'b0000, 1, 1, 0, 1, 5, 0);
        add_vec(4'b0000, 4'b0000, 4'b0000, 0, 1, 0, 1, 5, 0);
        add_vec(4'b0000, 4'b0000, 4'b0000, 0, 1, 0, 1, 5, 0);
        // racer 2 run: other done bits and its own ready drop are ignored
        add_vec(4'b0100, 4'b0000, 4'b0100, 1, 2, 0, 1, 5, 0);
        add_vec(4'b0100, 4'b1001, 4'b0100, 1, 2, 0, 1, 5, 0);
        add_vec(4'b0000, 4'b0000, 4'b0100, 1, 2, 0, 1, 5, 0);
        add_vec(4'b0000, 4'b1000, 4'b0100, 1, 2, 0, 1, 5, 0);
        add_vec(4'b0000, 4'b0100, 4'b0000, 1, 2, 1, 2, 3, 0);
        add_vec(4'b0000, 4'b0000, 4'b0000, 0, 2, 0, 2, 3, 0);
        // racer 3 finishes, then racer 0 wins although ready[3] is back
        add_vec(4'b1001, 4'b0000, 4'b1000, 1, 3, 0, 2, 3, 0);
        add_vec(4'b1001, 4'b1000, 4'b0000, 1, 3, 1, 3, 0, 0);
        add_vec(4'b1001, 4'b0000, 4'b0000, 1, 3, 0, 3, 0, 0);
        add_vec(4'b0001, 4'b0000, 4'b0000, 0, 3, 0, 3, 0, 0);
        add_vec(4'b1001, 4'b0000, 4'b0001, 1, 0, 0, 3, 0, 0);
        add_vec(4'b1001, 4'b0001, 4'b0000, 1, 0, 1, 0, 0, 0);
        add_vec(4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);

        // reset
        rst_l = 1'b0;
        ready = '0;
        done  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {start, busy, grant_id, result_valid, result_id, result_time, result_timeout, state_dbg},
              64'd0);
        rst_l = 1'b1;
        step();
        check("idle_after_reset", {start, busy, result_valid}, 64'd0);

        // table-driven vectors
        for (int k = 0; k < vecs.size(); k++) begin
            ready = vecs[k].ready;
            done  = vecs[k].done;
            step();
            check($sformatf("vec[%0d]", k),
                  {start, busy, grant_id, result_valid, result_id, result_time, result_timeout},
                  {vecs[k].start, vecs[k].busy, vecs[k].grant, vecs[k].rv, vecs[k].rid,
                   vecs[k].rtime, vecs[k].rto});
        end

        // reset mid-run: racer 1 running, one-cycle reset
        ready = 4'b0010;
        done  = '0;
        step();
        check("midrun_start", {start, grant_id}, {4'b0010, 2'd1});
        step();
        rst_l = 1'b0;
        #1;
        check("midrun_reset_async",
              {start, busy, grant_id, result_valid, result_id, result_time}, 64'd0);
        step();
        check("midrun_reset_hold", {start, busy, result_valid}, 64'd0);
        rst_l = 1'b1;
        ready = 4'b1111;

        // round-robin with all racers requesting; grants resume from racer 0
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd0);
        for (int k = 0; k < 5; k++) begin
            eid = exp_q.pop_front();
            waited = 0;
            step();
            while (start == '0 && waited < 10) begin
                step();
                waited++;
            end
            if (start == '0) begin
                check($sformatf("rr_wait[%0d]", k), 64'd0, 64'd1);
                break;
            end
            check($sformatf("rr_grant[%0d]", k), {onehot_to_id(start), grant_id}, {eid, eid});
            step();
            step();
            done[eid] = 1'b1;
            step();
            check($sformatf("rr_result[%0d]", k),
                  {start, result_valid, result_id, result_time, result_timeout},
                  {4'b0000, 1'b1, eid, 16'd2, 1'b0});
            done[eid]  = 1'b0;
            ready[eid] = 1'b0;
            step();
            check($sformatf("rr_cool_exit[%0d]", k), {start, busy, result_valid}, 64'd0);
            ready[eid] = 1'b1;
        end

        // long run on racer 2 (rr_ptr is 1, only racer 2 requests)
        ready = 4'b0100;
        step();
        check("long_grant", {start, grant_id}, {4'b0100, 2'd2});
`ifdef RACE_TIMEOUT_EN
        cnt = 1;
        while (start != '0 && cnt < 30) begin
            step();
            if (start != '0) cnt++;
        end
        check("timeout_start_cycles", 64'(cnt), 64'd8);
        check("timeout_result",
              {start, result_valid, result_id, result_time, result_timeout},
              {4'b0000, 1'b1, 2'd2, 16'd8, 1'b1});
`else
        cnt = 0;
        repeat (19) step();
        check("no_abort_start_held", {start, busy, result_valid}, {4'b0100, 1'b1, 1'b0});
        done[2] = 1'b1;
        step();
        check("long_result",
              {start, result_valid, result_id, result_time, result_timeout},
              {4'b0000, 1'b1, 2'd2, 16'd19, 1'b0});
`endif
        ready = '0;
        done  = '0;
        step();
        check("final_idle", {start, busy, result_valid}, 64'd0);
        step();
        check("result_hold_after_pulse", {result_valid, result_id}, {1'b0, 2'd2});

        check("start_onehot", 64'(onehot_viol), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
